// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter from the instruction and data masters onto six
// memory-mapped slaves. It returns a decode error for unmapped addresses and aborts slaves that stay silent too long.
module mem_arbiter #(
    parameter logic [31:0] rom_base_addr   = 32'h0,
    parameter logic [31:0] rom_top_addr    = 32'h80,
    parameter logic [31:0] uart_base_addr  = 32'h1000000,
    parameter logic [31:0] uart_top_addr   = 32'h1000004,
    parameter logic [31:0] clint_base_addr = 32'h2000000,
    parameter logic [31:0] clint_top_addr  = 32'h200C000,
    parameter logic [31:0] tim0_base_addr  = 32'h10000000,
    parameter logic [31:0] tim0_top_addr   = 32'h10100000,
    parameter logic [31:0] tim1_base_addr  = 32'h20000000,
    parameter logic [31:0] tim1_top_addr   = 32'h20100000,
    parameter logic [31:0] ram_base_addr   = 32'h80000000,
    parameter logic [31:0] ram_top_addr    = 32'h90000000,
    parameter int          timeout_cycles  = 1024
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         imem_valid,
    input  logic [31:0]  imem_addr,
    input  logic [31:0]  imem_wdata,
    input  logic [3:0]   imem_wstrb,
    output logic [31:0]  imem_rdata,
    output logic         imem_ready,
    output logic         imem_error,
    input  logic         dmem_valid,
    input  logic [31:0]  dmem_addr,
    input  logic [31:0]  dmem_wdata,
    input  logic [3:0]   dmem_wstrb,
    output logic [31:0]  dmem_rdata,
    output logic         dmem_ready,
    output logic         dmem_error,
    output logic [5:0]   slv_valid,
    output logic [31:0]  slv_addr,
    output logic [31:0]  slv_wdata,
    output logic [3:0]   slv_wstrb,
    input  logic [191:0] slv_rdata,
    input  logic [5:0]   slv_ready
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    localparam int CW = $clog2(timeout_cycles);
    localparam logic [CW-1:0] CNT_LAST = CW'(timeout_cycles - 1);
    localparam logic [5:0][31:0] BASE = {ram_base_addr, tim1_base_addr, tim0_base_addr,
                                         clint_base_addr, uart_base_addr, rom_base_addr};
    localparam logic [5:0][31:0] TOP = {ram_top_addr, tim1_top_addr, tim0_top_addr,
                                        clint_top_addr, uart_top_addr, rom_top_addr};

    logic [0:0]       state;
    logic [2:0]       sel;
    logic             mid;
    logic             last_grant;
    logic [CW-1:0]    cnt;
    logic [1:0]       p_valid;
    logic [1:0][31:0] p_addr;
    logic [1:0][31:0] p_wdata;
    logic [1:0][3:0]  p_wstrb;
    logic [1:0]       in_valid;
    logic [1:0][31:0] in_addr;
    logic [1:0][31:0] in_wdata;
    logic [1:0][3:0]  in_wstrb;
    logic [1:0]       cand;
    logic [1:0]       ready_q;
    logic [1:0]       error_q;
    logic [1:0][31:0] rdata_q;
    logic [5:0][31:0] srd;
    logic             gnt;
    logic             hit;
    logic [2:0]       idx;
    logic [31:0]      c_addr;
    logic [31:0]      c_wdata;
    logic [3:0]       c_wstrb;
    logic             sel_ready;
    logic             done;
    logic             issue;

    assign in_valid = {dmem_valid, imem_valid};
    assign in_addr  = {dmem_addr, imem_addr};
    assign in_wdata = {dmem_wdata, imem_wdata};
    assign in_wstrb = {dmem_wstrb, imem_wstrb};
    assign srd      = slv_rdata;

    // A held request takes precedence over a new pulse from the same master.
    assign cand    = p_valid | in_valid;
    assign gnt     = &cand ? ~last_grant : cand[1];
    assign c_addr  = p_valid[gnt] ? p_addr[gnt] : in_addr[gnt];
    assign c_wdata = p_valid[gnt] ? p_wdata[gnt] : in_wdata[gnt];
    assign c_wstrb = p_valid[gnt] ? p_wstrb[gnt] : in_wstrb[gnt];

    assign sel_ready = slv_ready[sel];
    assign done      = state == WAIT && (sel_ready || cnt == CNT_LAST);
    assign issue     = |cand && (state == IDLE || done);

    // The lowest-numbered region wins if regions are configured to overlap.
    always_comb begin
        hit = 1'b0;
        idx = 3'd0;
        for (int i = 5; i >= 0; i--)
            if (c_addr >= BASE[i] && c_addr < TOP[i]) begin
                hit = 1'b1;
                idx = 3'(i);
            end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sel        <= '0;
            mid        <= 1'b0;
            last_grant <= 1'b0;
            cnt        <= '0;
            p_valid    <= '0;
            p_addr     <= '0;
            p_wdata    <= '0;
            p_wstrb    <= '0;
            ready_q    <= '0;
            error_q    <= '0;
            rdata_q    <= '0;
            slv_valid  <= '0;
            slv_addr   <= '0;
            slv_wdata  <= '0;
            slv_wstrb  <= '0;
        end else begin
            ready_q   <= '0;
            error_q   <= '0;
            rdata_q   <= '0;
            slv_valid <= '0;
            if (state == WAIT) begin
                cnt <= cnt + 1'b1;
                if (done) begin
                    state        <= IDLE;
                    ready_q[mid] <= 1'b1;
                    error_q[mid] <= ~sel_ready;
                    rdata_q[mid] <= sel_ready ? srd[sel] : '0;
                end
            end
            if (issue) begin
                last_grant <= gnt;
                if (hit) begin
                    state     <= WAIT;
                    sel       <= idx;
                    mid       <= gnt;
                    cnt       <= '0;
                    slv_valid <= 6'b1 << idx;
                    slv_addr  <= c_addr;
                    slv_wdata <= c_wdata;
                    slv_wstrb <= c_wstrb;
                end else begin
                    ready_q[gnt] <= 1'b1;
                    error_q[gnt] <= 1'b1;
                end
            end
            for (int m = 0; m < 2; m++)
                if (issue && gnt == 1'(m))
                    p_valid[m] <= 1'b0;
                else if (in_valid[m]) begin
                    p_valid[m] <= 1'b1;
                    p_addr[m]  <= in_addr[m];
                    p_wdata[m] <= in_wdata[m];
                    p_wstrb[m] <= in_wstrb[m];
                end
        end
    end

    assign imem_ready = ready_q[0];
    assign imem_error = error_q[0];
    assign imem_rdata = rdata_q[0];
    assign dmem_ready = ready_q[1];
    assign dmem_error = error_q[1];
    assign dmem_rdata = rdata_q[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level model of the two masters, the memory map and the response timing.
module tb_mem_arbiter;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             imem_valid = 1'b0, dmem_valid = 1'b0;
    logic [31:0]      imem_addr = '0, dmem_addr = '0, imem_wdata = '0, dmem_wdata = '0;
    logic [3:0]       imem_wstrb = '0, dmem_wstrb = '0;
    logic [31:0]      imem_rdata, dmem_rdata;
    logic             imem_ready, dmem_ready, imem_error, dmem_error;
    logic [5:0]       slv_valid;
    logic [31:0]      slv_addr, slv_wdata;
    logic [3:0]       slv_wstrb;
    logic [5:0][31:0] srd = '0;
    logic [5:0]       slv_ready = '0;

    int total = 0;
    int bad = 0;

    mem_arbiter #(.timeout_cycles(TO)) dut (
        .clock(clk), .reset(rst_n),
        .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_wstrb(imem_wstrb), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .imem_error(imem_error),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .dmem_error(dmem_error),
        .slv_valid(slv_valid), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
        .slv_wstrb(slv_wstrb), .slv_rdata(srd), .slv_ready(slv_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory map as written in the block description: base inclusive, top exclusive.
    logic [31:0] reg_lo [6] = '{32'h0, 32'h1000000, 32'h2000000, 32'h10000000, 32'h20000000, 32'h80000000};
    logic [31:0] reg_hi [6] = '{32'h80, 32'h1000004, 32'h200C000, 32'h10100000, 32'h20100000, 32'h90000000};

    function automatic int dec(logic [31:0] a);
        for (int i = 0; i < 6; i++)
            if (a >= reg_lo[i] && a < reg_hi[i]) return i;
        return -1;
    endfunction

    // Model: each master has at most one waiting request; one slave transaction in flight.
    logic [1:0]  e_rdy = '0, e_err = '0;
    logic [31:0] e_rd [2] = '{32'h0, 32'h0};
    logic [5:0]  e_sv = '0;
    logic [31:0] e_sa = '0, e_sw = '0;
    logic [3:0]  e_ss = '0;
    bit          m_busy;
    int          m_cm, m_cs, m_age, m_last;
    bit          q_has [2];
    logic [31:0] q_a [2], q_w [2];
    logic [3:0]  q_s [2];

    task automatic model_clr();
        m_busy = 0; m_cm = 0; m_cs = 0; m_age = 0; m_last = 0;
        q_has[0] = 0; q_has[1] = 0;
        e_rdy = '0; e_err = '0; e_rd[0] = '0; e_rd[1] = '0;
        e_sv = '0; e_sa = '0; e_sw = '0; e_ss = '0;
    endtask

    task automatic model_step();
        int w, s;
        e_rdy = '0; e_err = '0; e_rd[0] = '0; e_rd[1] = '0; e_sv = '0;
        if (m_busy) begin
            if (slv_ready[m_cs]) begin
                e_rdy[m_cm] = 1'b1; e_rd[m_cm] = srd[m_cs]; m_busy = 0;
            end else if (m_age == TO - 1) begin
                e_rdy[m_cm] = 1'b1; e_err[m_cm] = 1'b1; m_busy = 0;
            end else m_age++;
        end
        if (imem_valid) begin q_has[0] = 1; q_a[0] = imem_addr; q_w[0] = imem_wdata; q_s[0] = imem_wstrb; end
        if (dmem_valid) begin q_has[1] = 1; q_a[1] = dmem_addr; q_w[1] = dmem_wdata; q_s[1] = dmem_wstrb; end
        if (!m_busy && (q_has[0] || q_has[1])) begin
            w = (q_has[0] && q_has[1]) ? 1 - m_last : (q_has[1] ? 1 : 0);
            m_last = w;
            q_has[w] = 0;
            s = dec(q_a[w]);
            if (s < 0) begin
                e_rdy[w] = 1'b1; e_err[w] = 1'b1;
            end else begin
                e_sv = 6'b1 << s; e_sa = q_a[w]; e_sw = q_w[w]; e_ss = q_s[w];
                m_busy = 1; m_cm = w; m_cs = s; m_age = 0;
            end
        end
    endtask

    initial begin
        model_clr();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_clr();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        chk("imem_ready", 32'(imem_ready), 32'(e_rdy[0]));
        chk("dmem_ready", 32'(dmem_ready), 32'(e_rdy[1]));
        chk("imem_error", 32'(imem_error), 32'(e_err[0]));
        chk("dmem_error", 32'(dmem_error), 32'(e_err[1]));
        if (e_rdy[0]) chk("imem_rdata", imem_rdata, e_rd[0]);
        if (e_rdy[1]) chk("dmem_rdata", dmem_rdata, e_rd[1]);
        chk("slv_valid", 32'(slv_valid), 32'(e_sv));
        chk("slv_addr", slv_addr, e_sa);
        chk("slv_wdata", slv_wdata, e_sw);
        chk("slv_wstrb", 32'(slv_wstrb), 32'(e_ss));
    end

    // Stimulus agents: masters with one outstanding request, slaves with random latency.
    bit auto_mst = 0, auto_slv = 0, fair = 0, act = 0;
    bit out [2] = '{0, 0};
    int sd = 0, tgt = 0, rate = 0;
    int gq [$];
    logic [31:0] atab [16] = '{32'h0, 32'h7C, 32'h80, 32'h1000000, 32'h1000003, 32'h1000004,
                              32'h200BFFC, 32'h200C000, 32'h10000000, 32'h100FFFFC, 32'h20000000,
                              32'h20100000, 32'h80000000, 32'h8FFFFFFC, 32'h90000000, 32'h40000000};

    task automatic step();
        logic [31:0] a, wd;
        logic [3:0]  ws;
        @(negedge clk);
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        if (fair) begin
            if (slv_valid[0]) gq.push_back(0);
            if (slv_valid[5]) gq.push_back(1);
        end
        if (auto_slv) begin
            slv_ready = 6'($urandom) & 6'($urandom) & 6'($urandom);
            for (int i = 0; i < 6; i++) srd[i] = $urandom;
            if (slv_valid != 6'b0) begin
                act = 1;
                sd = int'($urandom_range(4));
                for (int i = 0; i < 6; i++) if (slv_valid[i]) tgt = i;
            end
            if (act) begin
                slv_ready[tgt] = (sd == 0);
                if (sd == 0) act = 0; else sd--;
            end
        end else slv_ready = '0;
        if (imem_ready) out[0] = 0;
        if (dmem_ready) out[1] = 0;
        for (int m = 0; m < 2; m++)
            if ((auto_mst || fair) && !out[m] && int'($urandom_range(99)) < rate) begin
                out[m] = 1;
                a  = fair ? (m == 1 ? 32'h80000100 : 32'h10) : atab[$urandom_range(15)];
                wd = $urandom;
                ws = ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0;
                if (m == 0) begin imem_valid = 1; imem_addr = a; imem_wdata = wd; imem_wstrb = ws; end
                else begin dmem_valid = 1; dmem_addr = a; dmem_wdata = wd; dmem_wstrb = ws; end
            end
    endtask

    initial begin
        int seen;
        repeat (3) step();
        chk("rst_slv_valid", 32'(slv_valid), 32'h0);
        chk("rst_slv_addr", slv_addr, 32'h0);
        chk("rst_ready", 32'({imem_ready, dmem_ready, imem_error, dmem_error}), 32'h0);
        rst_n = 1'b1;
        step();

        // Simultaneous requests after reset: dmem (uart) first, then imem (rom) back-to-back.
        step();
        imem_valid = 1; imem_addr = 32'h4; imem_wstrb = 4'h0;
        dmem_valid = 1; dmem_addr = 32'h1000000; dmem_wstrb = 4'h0;
        step();
        chk("sim_uart_issue", 32'(slv_valid), 32'h02);
        chk("sim_uart_addr", slv_addr, 32'h1000000);
        step();
        slv_ready = 6'b000010; srd[1] = 32'h55;
        step();
        chk("sim_dmem_ready", 32'(dmem_ready), 32'h1);
        chk("sim_dmem_rdata", dmem_rdata, 32'h55);
        chk("sim_rom_issue", 32'(slv_valid), 32'h01);
        chk("sim_rom_addr", slv_addr, 32'h4);
        chk("sim_imem_early", 32'(imem_ready), 32'h0);
        slv_ready = 6'b000001; srd[0] = 32'h1234;
        step();
        chk("sim_imem_ready", 32'(imem_ready), 32'h1);
        chk("sim_imem_rdata", imem_rdata, 32'h1234);
        chk("sim_dmem_once", 32'(dmem_ready), 32'h0);
        step();

        // Ram read: slave ready 3 cycles after valid, master ready 4 cycles after valid.
        step();
        dmem_valid = 1; dmem_addr = 32'h80000010; dmem_wstrb = 4'h0;
        step();
        chk("ram_issue", 32'(slv_valid), 32'h20);
        step();
        step();
        chk("ram_not_yet", 32'(dmem_ready), 32'h0);
        slv_ready = 6'b100000; srd[5] = 32'hDEADBEEF;
        step();
        chk("ram_ready", 32'(dmem_ready), 32'h1);
        chk("ram_rdata", dmem_rdata, 32'hDEADBEEF);
        chk("ram_error", 32'(dmem_error), 32'h0);

        // Unmapped address.
        step();
        dmem_valid = 1; dmem_addr = 32'h40000000;
        step();
        chk("unm_ready", 32'(dmem_ready), 32'h1);
        chk("unm_error", 32'(dmem_error), 32'h1);
        chk("unm_rdata", dmem_rdata, 32'h0);
        chk("unm_no_slave", 32'(slv_valid), 32'h0);

        // Clint last word hits; non-selected readies are ignored; one past top is an error.
        step();
        dmem_valid = 1; dmem_addr = 32'h200BFFC; dmem_wdata = 32'hA5A5; dmem_wstrb = 4'hF;
        step();
        chk("clint_issue", 32'(slv_valid), 32'h04);
        chk("clint_wdata", slv_wdata, 32'hA5A5);
        slv_ready = 6'b100001;
        step();
        chk("clint_ignore_other", 32'(dmem_ready), 32'h0);
        slv_ready = 6'b000100; srd[2] = 32'h77;
        step();
        chk("clint_ready", 32'(dmem_ready), 32'h1);
        chk("clint_rdata", dmem_rdata, 32'h77);
        step();
        dmem_valid = 1; dmem_addr = 32'h200C000; dmem_wstrb = 4'h0;
        step();
        chk("clint_top_err", 32'({dmem_ready, dmem_error}), 32'h3);

        // Timeout on tim0, late ready ignored, next request normal.
        step();
        imem_valid = 1; imem_addr = 32'h10000000; imem_wstrb = 4'h0;
        step();
        chk("to_issue", 32'(slv_valid), 32'h08);
        for (int k = 1; k < TO; k++) begin
            step();
            chk("to_wait", 32'(imem_ready), 32'h0);
        end
        step();
        chk("to_ready", 32'(imem_ready), 32'h1);
        chk("to_error", 32'(imem_error), 32'h1);
        chk("to_rdata", imem_rdata, 32'h0);
        step();
        slv_ready = 6'b001000;
        step();
        chk("to_late_ignored", 32'(imem_ready), 32'h0);
        dmem_valid = 1; dmem_addr = 32'h80000000;
        step();
        chk("after_to_issue", 32'(slv_valid), 32'h20);
        slv_ready = 6'b100000; srd[5] = 32'hCAFE;
        step();
        chk("after_to_ready", 32'({dmem_ready, dmem_error}), 32'h2);
        chk("after_to_rdata", dmem_rdata, 32'hCAFE);

        // Fairness: both masters re-request continuously.
        gq.delete();
        auto_slv = 1; fair = 1; rate = 100;
        for (int k = 0; k < 400 && gq.size() < 10; k++) step();
        fair = 0;
        chk("fair_count", 32'(gq.size() >= 10), 32'h1);
        for (int i = 1; i < gq.size() && i < 10; i++) chk("fair_alt", 32'(gq[i]), 32'(1 - gq[i-1]));
        for (int k = 0; k < 300 && (out[0] || out[1]); k++) step();
        chk("fair_drain", 32'(out[0] | out[1]), 32'h0);

        // Random traffic.
        auto_mst = 1; rate = 30;
        repeat (3000) step();
        auto_mst = 0;
        for (int k = 0; k < 300 && (out[0] || out[1]); k++) step();
        chk("rand_drain", 32'(out[0] | out[1]), 32'h0);
        repeat (3) step();
        auto_slv = 0; act = 0;

        // Reset while waiting on tim1.
        step();
        imem_valid = 1; imem_addr = 32'h20000000; imem_wstrb = 4'h0;
        step();
        chk("rw_issue", 32'(slv_valid), 32'h10);
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("rw_async_addr", slv_addr, 32'h0);
        chk("rw_async_out", 32'({slv_valid, imem_ready, dmem_ready}), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            step();
            if (imem_ready || dmem_ready) seen++;
        end
        chk("rw_no_response", 32'(seen), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, six-slave memory interconnect between the core's instruction and data ports and the SoC slaves. The slaves are rom, uart, clint, tim0, tim1 and ram. The block captures single-cycle request pulses and arbitrates round-robin. It decodes the address against the system memory map, issues one transaction at a time, and returns a single-cycle ready/rdata pulse to the winning master. Unmapped addresses get an error response. A slave that never answers is aborted after a timeout.

## Interface
- rom_base_addr / rom_top_addr, default 32'h0 / 32'h80: rom region, base inclusive, top exclusive
- uart_base_addr / uart_top_addr, default 32'h1000000 / 32'h1000004: uart region
- clint_base_addr / clint_top_addr, default 32'h2000000 / 32'h200C000: clint region
- tim0_base_addr / tim0_top_addr, default 32'h10000000 / 32'h10100000: tim0 region
- tim1_base_addr / tim1_top_addr, default 32'h20000000 / 32'h20100000: tim1 region
- ram_base_addr / ram_top_addr, default 32'h80000000 / 32'h90000000: ram region
- timeout_cycles, default 1024: cycles to wait for slave ready before abort (≥2)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- imem_valid / dmem_valid  in  1  request pulse, exactly one cycle
- imem_addr / dmem_addr  in  32  byte address
- imem_wdata / dmem_wdata  in  32  write data
- imem_wstrb / dmem_wstrb  in  4  byte strobes; 0 means read
- imem_rdata / dmem_rdata  out  32  read data, valid while the matching ready is high
- imem_ready / dmem_ready  out  1  completion pulse, one cycle
- imem_error / dmem_error  out  1  high with ready on decode error or timeout
- slv_valid  out  6  one-hot request pulse; bit order: 0 rom, 1 uart, 2 clint, 3 tim0, 4 tim1, 5 ram
- slv_addr  out  32  full byte address, held for the whole transaction
- slv_wdata  out  32  held for the whole transaction
- slv_wstrb  out  4  held for the whole transaction
- slv_rdata  in  192  packed; slave i drives bits [32i+31:32i]
- slv_ready  in  6  per-slave completion

## Operation
- States:
  - IDLE: no transaction in flight.
  - WAIT: transaction issued, waiting for the selected slave's ready or for timeout.
- Pending registers: one per master. Each holds addr/wdata/wstrb and is loaded when that master's valid arrives and the request is not issued that cycle.
- Issue point is any edge where the state is IDLE, or WAIT with a completion in that cycle.
- Candidate per master at an issue point: its pending request, otherwise its incoming valid.
- Arbitration:
  - One candidate: it wins.
  - Two candidates: the master not granted last wins.
  - last_grant resets to imem, so the first conflict goes to dmem.
  - The loser goes to, or stays in, its pending register.
- Decode: match addr against the six regions (base ≤ addr < top).
  - Hit: pulse slv_valid[i], latch slave index and master id, reset the timeout counter, go to WAIT.
  - Miss: no slave access. Return master ready=1, error=1, rdata=0 on the next cycle. State unchanged. Counts as a grant for round-robin.
- WAIT:
  - Only slv_ready[sel] is monitored; other ready bits are ignored.
  - On slv_ready[sel]: capture slv_rdata[sel] and pulse the master's ready with error=0. Go to IDLE, or re-issue if a candidate exists.
  - Timeout: counter increments each WAIT cycle. When it reaches timeout_cycles: pulse ready with error=1 and rdata=0, return to IDLE. A later ready from the aborted slave is ignored.
- Writes return ready with rdata equal to whatever the slave drove. Masters ignore rdata on writes.
- A master must not pulse valid again before receiving ready. Behaviour is undefined if it does.
- Reset mid-transaction: all state is discarded immediately and no response is ever returned. Slaves must also be reset.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Pending registers empty.
  - Timeout counter 0.
  - last_grant = imem.
- All outputs are registered.
- Mapped request, valid at cycle t with the block idle: slv_valid high in cycle t+1 only.
- Slave may assert ready in cycle t+1 or later (cycle r). Master ready/rdata are high in cycle r+1. Minimum latency is 2 cycles.
- Unmapped request at cycle t: master ready+error in cycle t+1.
- Back-to-back: with completion at cycle r and a candidate present, the next slv_valid fires in cycle r+1, coincident with the previous master's ready.
- Timeout: issue at t+1 with no ready → error ready in cycle t+1+timeout_cycles.
- slv_addr, slv_wdata and slv_wstrb remain stable from the slv_valid cycle through the ready cycle.

## Test plan
- Read from ram: dmem_valid, addr 32'h80000010; slave 5 gives ready 3 cycles after valid with rdata 32'hDEADBEEF → dmem_ready and dmem_rdata=32'hDEADBEEF, error=0, 4 cycles after dmem_valid.
- Simultaneous requests: imem to rom 32'h4 and dmem to uart 32'h1000000 in the same cycle after reset → uart issued first. rom issues in the cycle after uart ready. Each master gets exactly one ready.
- Fairness: both masters continuously re-request after each completion for 10 transactions → grants strictly alternate. Neither master is granted twice in a row.
- Unmapped: dmem read at 32'h40000000 → dmem_ready=1, dmem_error=1, rdata=0 in the next cycle. slv_valid stays 0.
- Timeout: timeout_cycles=16, imem read to tim0 32'h10000000 with no ready → imem_error pulse exactly 16 cycles after slv_valid[3]. A later tim0 ready is ignored and the next request proceeds normally.
- Boundaries and reset: addr 32'h200BFFC hits clint; 32'h200C000 gives an error. Asserting reset in WAIT clears all outputs asynchronously and returns no ready after release.
